ex_mul_stage: RTL and testbench
===============================

# ex_mul_stage

Execute stage directly upstream of the EX/MEM pipeline register: it takes decoded operands, computes the ALU result, and drives the `wb`, `ALU_result` and `dst_addr` inputs that the EX/MEM register captures every `clk` edge. Single-cycle ops complete combinationally in the same cycle. `MUL` runs on an iterative 32-cycle shift-add engine. While `MUL` is busy, the stage stalls upstream via `ready_out` and presents bubbles (`wb_out=0`) to EX/MEM, because that register has no enable.

## Interface
- `MUL_CYCLES`, default 32: number of iterations in `BUSY` (one multiplier bit per cycle). Only the value 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_in` input 1: upstream presents an instruction this cycle.
- `wb_in` input 1: instruction writes the register file.
- `alu_op` input 4: operation select. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA, 9 MUL. Codes 10–15 are reserved.
- `src1`, `src2` input 32 each: operands.
- `dst_addr_in` input 5: destination register.
- `flush` input 1: synchronous abort of the in-flight instruction.
- `ready_out` output 1: stage accepts `valid_in` this cycle.
- `wb_out` output 1: to EX/MEM `wb_in`.
- `ALU_result_out` output 32: to EX/MEM `ALU_result_in`.
- `dst_addr_out` output 5: to EX/MEM `dst_addr_in`.

## Operation
- FSM states: `IDLE`, `BUSY`, `DONE`. State register, 6-bit iteration counter, 32-bit multiplicand/multiplier/product registers, latched `wb` and `dst`.
- **IDLE, `ready_out=1`**
  - `valid_in=1`, op≠MUL: outputs are combinational from the inputs.
    - `ALU_result_out` = op result.
    - `dst_addr_out` = `dst_addr_in`.
    - `wb_out` = `wb_in & (dst_addr_in!=0)`.
    - State stays `IDLE`.
  - `valid_in=1`, op=MUL:
    - Latch `src1`, `src2`, `wb_in`, `dst_addr_in`; clear product and counter.
    - Present a bubble this cycle: all outputs 0.
    - Next state `BUSY`.
  - `valid_in=0`: all outputs 0.
- **BUSY, `ready_out=0`, outputs all 0**
  - Each cycle: if `multiplier[0]`, product += multiplicand (mod 2^32).
  - Then multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - After iteration 32 (counter reaches 31 and increments), next state `DONE`.
- **DONE, `ready_out=0`**
  - `ALU_result_out` = product (low 32 bits of `src1*src2`; signedness is irrelevant for the low half).
  - `dst_addr_out` = latched dst.
  - `wb_out` = latched wb & (dst!=0).
  - Next state `IDLE`.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^32; there is no overflow flag.
  - SLT yields 32'd1 or 32'd0 (signed compare).
  - Shifts use `src2[4:0]` only. SRA sign-extends.
- Reserved opcodes: `ALU_result_out=0`, `wb_out` forced 0, `dst_addr_out` passed through.
- `flush=1` (sampled at the clock edge):
  - Next state `IDLE` regardless of the current state; counter cleared.
  - In the same cycle, `wb_out` is forced 0 in every state, so a flushed instruction never writes back.
  - `flush` takes priority over acceptance: with `flush=1` in `IDLE`, a MUL is not accepted.
- `valid_in` is ignored whenever `ready_out=0`. Upstream must hold its next instruction until `ready_out=1`.
- Reset (`rst_n=0`), asynchronous:
  - Outputs: state `IDLE`, all datapath registers 0, `ready_out=0`, `wb_out=0`, `ALU_result_out=0`, `dst_addr_out=0`.
  - Mid-operation: a reset during `BUSY` or `DONE` aborts the multiply with no writeback.
  - After deassertion: `IDLE` behaviour begins in the same cycle.

## Timing
- Single-cycle op: zero latency through this stage, so EX/MEM holds the result after the next edge.
- MUL accepted at edge-cycle T:
  - T: bubble.
  - T+1..T+32: `BUSY`, bubbles.
  - T+33: `DONE`, result presented.
  - T+34: `IDLE`, `ready_out=1`; the next instruction can be accepted in this cycle.
- Back-to-back MULs: 34 cycles apart.
- `ready_out` is a pure function of state and `rst_n`; it has no combinational path from `valid_in`.

## Test plan
- **Reset:** hold `rst_n=0` with random inputs -> all outputs 0, `ready_out=0`. Release -> ADD 5+7, dst 3, wb 1 gives `ALU_result_out=12`, `wb_out=1`, `dst_addr_out=3`, same cycle.
- **ALU sweep:**
  - SUB 3-5 -> 0xFFFFFFFE.
  - SLT −1<1 -> 1.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLL with `src2=33` -> shift by 1.
  - dst 0 with wb 1 -> `wb_out=0`.
- **MUL:** 0x0001_0003 × 0x0000_0005 accepted at T -> bubbles T..T+32; at T+33 result 0x0005_000F with latched dst and wb; `ready_out=1` at T+34. Also 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000001.
- **Stall:** during `BUSY`, drive `valid_in=1` ADD with changing operands -> no effect on outputs or on the product; the ADD is accepted only at T+34.
- **Flush:** `flush=1` at T+10 of a MUL -> `IDLE` the next cycle, no `wb_out=1` ever produced for that MUL; `flush=1` in `DONE` -> `wb_out=0` that cycle.
- **Async reset mid-MUL:** assert `rst_n=0` between edges at T+20 -> outputs 0 immediately; after release, state is `IDLE` and a new MUL 6×7 yields 42 at 33 cycles after acceptance.

Source files
------------

// File: rtl/ex_mul_stage.sv
// Execute stage feeding the EX/MEM register: single-cycle ALU ops resolve combinationally,
// MUL runs on a 32-iteration shift-add engine and stalls upstream until the result is presented.
module ex_mul_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        wb_in,
  input  logic [3:0]  alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [4:0]  dst_addr_in,
  input  logic        flush,
  output logic        ready_out,
  output logic        wb_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  dst_addr_out
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                         OP_SRA = 4'd8, OP_MUL = 4'd9;
  localparam logic [5:0] LAST_ITER = 6'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic       wb;
    logic [4:0] dst;
  } mul_ctx_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] mcand_q, mplier_q, prod_q;
  mul_ctx_t    ctx_q;

  logic [31:0] alu_res;
  logic        alu_ok;
  logic        accept_mul;

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (alu_op)
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SLT:  alu_res = {31'd0, $signed(src1) < $signed(src2)};
      OP_SLL:  alu_res = src1 << src2[4:0];
      OP_SRL:  alu_res = src1 >> src2[4:0];
      OP_SRA:  alu_res = $signed(src1) >>> src2[4:0];
      default: alu_ok  = 1'b0;  // MUL is handled by the engine; 10-15 reserved
    endcase
  end

  // flush wins over acceptance, so a flushed MUL never enters BUSY
  assign accept_mul = (state_q == IDLE) && valid_in && (alu_op == OP_MUL) && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_mul) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    ready_out      = rst_n && (state_q == IDLE);
    wb_out         = 1'b0;
    ALU_result_out = '0;
    dst_addr_out   = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: if (valid_in && alu_op != OP_MUL) begin
          ALU_result_out = alu_res;
          dst_addr_out   = dst_addr_in;
          wb_out         = wb_in && (dst_addr_in != 5'd0) && alu_ok && !flush;
        end
        DONE: begin
          ALU_result_out = prod_q;
          dst_addr_out   = ctx_q.dst;
          wb_out         = ctx_q.wb && (ctx_q.dst != 5'd0) && !flush;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      ctx_q    <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        cnt_q <= '0;
      end else if (accept_mul) begin
        mcand_q  <= src1;
        mplier_q <= src2;
        prod_q   <= '0;
        cnt_q    <= '0;
        ctx_q    <= '{wb: wb_in, dst: dst_addr_in};
      end else if (state_q == BUSY) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mul_stage.sv
// Directed bench for ex_mul_stage: expected results are queued at drive time and
// popped when the stage presents them; every check is an immediate assertion.
module tb_ex_mul_stage;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLT = 4'd5, SLL = 4'd6, SRL = 4'd7, SRA = 4'd8, MUL = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, wb_in, flush;
  logic [3:0]  alu_op;
  logic [31:0] src1, src2;
  logic [4:0]  dst_addr_in;
  logic        ready_out, wb_out;
  logic [31:0] ALU_result_out;
  logic [4:0]  dst_addr_out;

  always #5 clk = ~clk;

  ex_mul_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .wb_in(wb_in), .alu_op(alu_op),
    .src1(src1), .src2(src2), .dst_addr_in(dst_addr_in), .flush(flush),
    .ready_out(ready_out), .wb_out(wb_out), .ALU_result_out(ALU_result_out),
    .dst_addr_out(dst_addr_out)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wb;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] res, input logic [4:0] dst, input logic wb);
    exp_t e;
    e.tag = tag; e.res = res; e.dst = dst; e.wb = wb;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty obs=0 exp=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_res"}, ALU_result_out, e.res);
      chk({e.tag, "_dst"}, 32'(dst_addr_out), 32'(e.dst));
      chk({e.tag, "_wb"},  32'(wb_out), 32'(e.wb));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    valid_in = v; wb_in = wb; alu_op = op; src1 = a; src2 = b; dst_addr_in = d;
  endtask

  task automatic op1(input string tag, input logic v, input logic wb, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                     input logic [31:0] eres, input logic [4:0] edst, input logic ewb);
    cyc();
    drive(v, wb, op, a, b, d);
    push(tag, eres, edst, ewb);
    @(negedge clk);
    pop_cmp();
  endtask

  // Waits (bounded) for the queued MUL result; latency is counted from the accept cycle.
  task automatic wait_mul(input string tag, input int exp_lat);
    int n = 0;
    while (wb_out !== 1'b1 && n < 40) begin
      cyc();
      valid_in = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    pop_cmp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nonbubble, wbseen;
    rst_n = 1'b0; flush = 1'b0;
    drive(0, 0, ADD, 0, 0, 0);

    // reset holds everything quiet regardless of inputs, across clock edges
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(1, 1, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(1, 31)));
      @(negedge clk);
      chk("rst_ready", 32'(ready_out), 0);
      chk("rst_wb", 32'(wb_out), 0);
      chk("rst_res", ALU_result_out, 0);
      chk("rst_dst", 32'(dst_addr_out), 0);
    end
    rst_n = 1'b1;
    drive(1, 1, ADD, 5, 7, 3);
    push("post_rst_add", 12, 3, 1);
    #1;
    pop_cmp();
    chk("post_rst_ready", 32'(ready_out), 1);

    // single-cycle ALU sweep
    op1("sub",     1, 1, SUB,  3, 5, 1,                      32'hFFFFFFFE, 1, 1);
    op1("slt_t",   1, 1, SLT,  32'hFFFFFFFF, 1, 2,           32'd1, 2, 1);
    op1("slt_f",   1, 1, SLT,  1, 32'hFFFFFFFF, 2,           32'd0, 2, 1);
    op1("sra",     1, 1, SRA,  32'h80000000, 4, 3,           32'hF8000000, 3, 1);
    op1("srl",     1, 1, SRL,  32'h80000000, 4, 3,           32'h08000000, 3, 1);
    op1("sll33",   1, 1, SLL,  3, 33, 4,                     32'd6, 4, 1);
    op1("and",     1, 1, AND_, 32'hF0F0, 32'hFF00, 5,        32'hF000, 5, 1);
    op1("or",      1, 1, OR_,  32'hF0F0, 32'hFF00, 5,        32'hFFF0, 5, 1);
    op1("xor",     1, 1, XOR_, 32'hF0F0, 32'hFF00, 5,        32'h0FF0, 5, 1);
    op1("add_wrap",1, 1, ADD,  32'hFFFFFFFF, 1, 6,           32'd0, 6, 1);
    op1("dst0",    1, 1, ADD,  1, 2, 0,                      32'd3, 0, 0);
    op1("nowb",    1, 0, ADD,  1, 2, 7,                      32'd3, 7, 0);
    op1("rsvd",    1, 1, 4'd12, 32'h1234, 32'h5678, 6,       32'd0, 6, 0);
    op1("novalid", 0, 1, ADD,  9, 9, 9,                      32'd0, 0, 0);

    // MUL with an ADD held at the input throughout the stall
    cyc();
    drive(1, 1, MUL, 32'h00010003, 32'h00000005, 7);
    @(negedge clk);
    chk("mul1_T_res", ALU_result_out, 0);
    chk("mul1_T_wb", 32'(wb_out), 0);
    chk("mul1_T_ready", 32'(ready_out), 1);
    push("mul1", 32'h0005000F, 7, 1);
    nonbubble = 0;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      drive(1, 1, ADD, $urandom, $urandom, 5'($urandom_range(1, 31)));
      @(negedge clk);
      if (wb_out || ready_out || ALU_result_out != 0 || dst_addr_out != 0) nonbubble++;
    end
    chk("mul1_stall_bubbles", 32'(nonbubble), 0);
    cyc();
    drive(1, 1, ADD, 100, 23, 2);
    @(negedge clk);
    pop_cmp();
    chk("mul1_done_ready", 32'(ready_out), 0);
    cyc();
    @(negedge clk);
    chk("mul1_idle_ready", 32'(ready_out), 1);
    push("add_after_stall", 123, 2, 1);
    pop_cmp();

    // all-ones multiply wraps to 1
    cyc();
    drive(1, 1, MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 8);
    push("mul_ff", 32'h00000001, 8, 1);
    @(negedge clk);
    wait_mul("mul_ff", 33);

    // flush at T+10 aborts the MUL; it must never write back
    cyc();
    drive(1, 1, MUL, 3, 4, 9);
    @(negedge clk);
    wbseen = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      valid_in = 1'b0;
      if (k == 10) flush = 1'b1;
      @(negedge clk);
      if (wb_out) wbseen++;
    end
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_ready", 32'(ready_out), 1);
    for (int k = 0; k < 40; k++) begin
      cyc();
      @(negedge clk);
      if (wb_out || !ready_out) wbseen++;
    end
    chk("flush_busy_no_wb", 32'(wbseen), 0);

    // flush in IDLE blocks acceptance of a MUL
    cyc();
    flush = 1'b1;
    drive(1, 1, MUL, 2, 3, 4);
    @(negedge clk);
    chk("flush_idle_wb", 32'(wb_out), 0);
    cyc();
    flush = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    chk("flush_idle_not_accepted", 32'(ready_out), 1);

    // flush in DONE suppresses the writeback that cycle
    cyc();
    drive(1, 1, MUL, 2, 3, 4);
    @(negedge clk);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      valid_in = 1'b0;
    end
    cyc();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_done_wb", 32'(wb_out), 0);
    chk("flush_done_res", ALU_result_out, 6);
    chk("flush_done_ready", 32'(ready_out), 0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_done_idle", 32'(ready_out), 1);

    // asynchronous reset in the middle of BUSY
    cyc();
    drive(1, 1, MUL, 32'h1234, 32'h5678, 10);
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      valid_in = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready_out), 0);
    chk("arst_wb", 32'(wb_out), 0);
    chk("arst_res", ALU_result_out, 0);
    chk("arst_dst", 32'(dst_addr_out), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("arst_release_ready", 32'(ready_out), 1);
    drive(1, 1, MUL, 6, 7, 5);
    push("mul67", 42, 5, 1);
    @(negedge clk);
    wait_mul("mul67", 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
